// File: rtl/post_window_lrc_fill.sv
// post_window_lrc_fill
//   Streaming left-right consistency checker. Left/right disparity streams
//   arrive in raster order. One line of right disparities is kept in a line
//   buffer. Each left disparity d at column col is checked against a 1x1,
//   1x3, 1x5 or 1x7 window of right disparities centred on column
//   col - round(d). The result is a disparity plus a 2-bit status. Pixels
//   that fail can optionally be filled with the last consistent disparity
//   of the same row.
//
// Ports
//   clk, rst (async, active-low)
//   clken      global clock enable; 0 freezes everything, gates outputs
//   img_width  active pixels per line (>= 2)
//   range      maximum legal integer disparity
//   win_sel    00=1x1 01=1x3 10=1x5 11=1x7 (clipped to KMAX taps)
//   check_th   consistency threshold (same fixed-point format as disparity)
//   fill_en    1: failed pixels take last good row disparity, 0: output 0
//   valid_in, disp_L, disp_R   input pixel pair
//   valid_out, disp_out, flag_out, line_end   checked pixel, 2 cycles later
//   flag_out: 00 consistent, 01 inconsistent, 10 out-of-range, 11 invalid
module post_window_lrc_fill #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 8,
  parameter int AWIDTH = 11,
  parameter int KMAX   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] img_width,
  input  logic [8:0]        range,
  input  logic [1:0]        win_sel,
  input  logic [DWIDTH-1:0] check_th,
  input  logic              fill_en,
  input  logic              valid_in,
  input  logic [DWIDTH-1:0] disp_L,
  input  logic [DWIDTH-1:0] disp_R,
  output logic              valid_out,
  output logic [DWIDTH-1:0] disp_out,
  output logic [1:0]        flag_out,
  output logic              line_end
);

  localparam int DIW  = DWIDTH - FRAC + 1;               // rounded integer disparity
  localparam int TW   = ((DIW > AWIDTH) ? DIW : AWIDTH) + 1; // signed target column
  localparam int CW   = (DIW > 9) ? DIW : 9;
  localparam int HMAX = (KMAX - 1) / 2;
  localparam logic [DWIDTH:0] HALF = (DWIDTH+1)'(1) << (FRAC - 1);

  logic [DWIDTH-1:0] line_buf [2**AWIDTH];
  logic [AWIDTH-1:0] col;

  // stage 0
  logic                 accept;
  logic [DWIDTH:0]      l_round;
  logic [DIW-1:0]       d_int0;
  logic signed [TW-1:0] tgt0;
  logic                 last0;

  // stage 1
  logic                 s1_valid;
  logic [DWIDTH-1:0]    s1_L;
  logic [AWIDTH-1:0]    s1_col;
  logic signed [TW-1:0] s1_tgt;
  logic [DIW-1:0]       s1_dint;
  logic                 s1_last;

  // stage 2
  logic [1:0]           win_h;
  logic                 any_pass;
  logic signed [TW:0]   pos;
  logic [DWIDTH-1:0]    tap;
  logic [DWIDTH:0]      diff;
  logic [DWIDTH:0]      adiff;
  logic                 range_bad;
  logic [1:0]           flag2;
  logic [DWIDTH-1:0]    lg_eff;
  logic [DWIDTH-1:0]    disp2;

  // output registers
  logic                 vo_q;
  logic                 le_q;
  logic [DWIDTH-1:0]    disp_q;
  logic [1:0]           flag_q;
  logic [DWIDTH-1:0]    last_good;

  always_comb begin
    accept  = valid_in & clken;
    // one extra bit keeps the rounding add from overflowing
    l_round = {1'b0, disp_L} + HALF;
    d_int0  = DIW'(l_round >> FRAC);
    tgt0    = $signed(TW'(col)) - $signed(TW'(d_int0));
    last0   = (col == img_width - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (accept) line_buf[col] <= disp_R;
  end

  // Window taps. The buffer is read combinationally in the cycle after the
  // pixel's own column was written; columns beyond col still hold the
  // previous line and are excluded, so the buffer never needs clearing.
  always_comb begin
    win_h    = (int'(win_sel) > HMAX) ? 2'(HMAX) : win_sel;
    any_pass = 1'b0;
    pos      = '0;
    tap      = '0;
    diff     = '0;
    adiff    = '0;
    for (int unsigned k = 0; k <= 2 * HMAX; k++) begin
      pos   = (TW+1)'(s1_tgt) + (TW+1)'(k) - (TW+1)'(HMAX);
      tap   = line_buf[pos[AWIDTH-1:0]];
      diff  = {1'b0, s1_L} - {1'b0, tap};
      adiff = diff[DWIDTH] ? (~diff + 1'b1) : diff;
      if ((k + int'(win_h) >= HMAX) && (k <= HMAX + int'(win_h)) &&
          !pos[TW] && (pos <= $signed((TW+1)'(s1_col))) &&
          (adiff <= {1'b0, check_th}))
        any_pass = 1'b1;
    end
  end

  always_comb begin
    range_bad = CW'(s1_dint) > CW'(range);
    if (s1_L == '0)
      flag2 = 2'b11;
    else if (range_bad || s1_tgt[TW-1])
      flag2 = 2'b10;
    else if (!any_pass)
      flag2 = 2'b01;
    else
      flag2 = 2'b00;
    // fill never crosses a line: column 0 sees a cleared last_good
    lg_eff = (s1_col == '0) ? '0 : last_good;
    disp2  = (flag2 == 2'b00) ? s1_L : (fill_en ? lg_eff : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      s1_valid  <= 1'b0;
      s1_L      <= '0;
      s1_col    <= '0;
      s1_tgt    <= '0;
      s1_dint   <= '0;
      s1_last   <= 1'b0;
      vo_q      <= 1'b0;
      le_q      <= 1'b0;
      disp_q    <= '0;
      flag_q    <= '0;
      last_good <= '0;
    end else if (clken) begin
      if (accept) begin
        col     <= last0 ? '0 : col + 1'b1;
        s1_L    <= disp_L;
        s1_col  <= col;
        s1_tgt  <= tgt0;
        s1_dint <= d_int0;
        s1_last <= last0;
      end
      s1_valid <= valid_in;
      vo_q     <= s1_valid;
      le_q     <= s1_valid & s1_last;
      if (s1_valid) begin
        disp_q    <= disp2;
        flag_q    <= flag2;
        last_good <= (flag2 == 2'b00) ? s1_L : lg_eff;
      end
    end
  end

  // The registered pixel is presented only while clken is high, so each
  // pixel is visible in exactly one enabled cycle even across a stall.
  assign valid_out = vo_q & clken;
  assign line_end  = le_q & clken;
  assign disp_out  = disp_q;
  assign flag_out  = flag_q;

endmodule

// File: tb/tb_post_window_lrc_fill.sv
module tb_post_window_lrc_fill;
  localparam int DW = 16;
  localparam int FR = 8;
  localparam int AW = 11;
  localparam int KM = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clken = 1'b0;
  logic [AW-1:0] img_width = 11'd8;
  logic [8:0]    range_v = 9'd100;
  logic [1:0]    win_sel = 2'b00;
  logic [DW-1:0] check_th = 16'h0080;
  logic          fill_en = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] disp_L = '0;
  logic [DW-1:0] disp_R = '0;
  logic          valid_out;
  logic [DW-1:0] disp_out;
  logic [1:0]    flag_out;
  logic          line_end;

  post_window_lrc_fill #(.DWIDTH(DW), .FRAC(FR), .AWIDTH(AW), .KMAX(KM)) dut (
    .clk(clk), .rst(rst), .clken(clken), .img_width(img_width), .range(range_v),
    .win_sel(win_sel), .check_th(check_th), .fill_en(fill_en), .valid_in(valid_in),
    .disp_L(disp_L), .disp_R(disp_R), .valid_out(valid_out), .disp_out(disp_out),
    .flag_out(flag_out), .line_end(line_end)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-pixel rule evaluation over a row of right values.
  typedef struct { int d; int f; int le; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   m_col = 0;
  int   m_lg  = 0;
  int   rline [2048];
  bit   mon_en = 1'b0;

  function automatic exp_t model(input int L, input int R);
    exp_t e;
    int d, tgt, h, flag, pass, df;
    rline[m_col] = R;
    if (m_col == 0) m_lg = 0;
    d   = (L + (1 << (FR - 1))) >> FR;
    tgt = m_col - d;
    h   = (int'(win_sel) < (KM - 1) / 2) ? int'(win_sel) : (KM - 1) / 2;
    pass = 0;
    for (int p = tgt - h; p <= tgt + h; p++) begin
      if (p >= 0 && p <= m_col) begin
        df = (L > rline[p]) ? L - rline[p] : rline[p] - L;
        if (df <= int'(check_th)) pass = 1;
      end
    end
    if (L == 0) flag = 3;
    else if (d > int'(range_v) || tgt < 0) flag = 2;
    else if (pass == 0) flag = 1;
    else flag = 0;
    e.f  = flag;
    e.d  = (flag == 0) ? L : (fill_en ? m_lg : 0);
    if (flag == 0) m_lg = L;
    e.le = (m_col == int'(img_width) - 1) ? 1 : 0;
    m_col = (e.le != 0) ? 0 : m_col + 1;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (!clken) begin
        check("stall_valid_out", 32'(valid_out), 0);
        check("stall_line_end", 32'(line_end), 0);
      end else if (valid_out) begin
        if (sb.size() == 0) check("unexpected_output", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("disp_out", 32'(disp_out), mon_e.d);
          check("flag_out", 32'(flag_out), mon_e.f);
          check("line_end", 32'(line_end), mon_e.le);
        end
      end else begin
        check("idle_line_end", 32'(line_end), 0);
      end
    end
  end

  task automatic drive(input bit ce, input bit v, input int l, input int r);
    int lm, rm;
    lm = l & 'hFFFF;
    rm = r & 'hFFFF;
    clken    = ce;
    valid_in = v;
    disp_L   = DW'(lm);
    disp_R   = DW'(rm);
    if (ce && v) sb.push_back(model(lm, rm));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 0, 0);
  endtask

  int dl [64];
  int dr [64];

  task automatic fill_rows(input int l, input int r);
    for (int i = 0; i < 64; i++) begin
      dl[i] = l;
      dr[i] = r;
    end
  endtask

  task automatic send_line(input int w, input int stall_at);
    for (int c = 0; c < w; c++) begin
      if (c == stall_at) begin
        repeat (3) drive(1'b0, 1'b1, 'h7777, 'h7777);
        drive(1'b1, 1'b0, 'h1234, 'h1234);
      end
      drive(1'b1, 1'b1, dl[c], dr[c]);
    end
  endtask

  task automatic rand_line();
    int base, c;
    base = int'($urandom_range(0, 14)) * 256;
    c = 0;
    while (c < int'(img_width)) begin
      int r, l, rr;
      r = int'($urandom_range(0, 9));
      if (r == 0) drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom));
      else if (r == 1) drive(1'b1, 1'b0, int'($urandom), int'($urandom));
      else begin
        if ($urandom_range(0, 9) == 0) l = 0;
        else l = base + int'($urandom_range(0, 192)) - 96;
        if (l < 0) l = 1;
        if ($urandom_range(0, 5) == 0) rr = int'($urandom_range(0, 65535));
        else rr = base + int'($urandom_range(0, 192)) - 96;
        if (rr < 0) rr = 0;
        drive(1'b1, 1'b1, l, rr);
        c++;
      end
    end
  endtask

  initial begin
    // reset values
    @(negedge clk);
    check("reset_valid_out", 32'(valid_out), 0);
    check("reset_disp_out", 32'(disp_out), 0);
    check("reset_flag_out", 32'(flag_out), 0);
    check("reset_line_end", 32'(line_end), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // uniform match with a 3-cycle stall and a bubble at column 4
    img_width = 11'd8; range_v = 9'd100; win_sel = 2'b00; check_th = 16'h0080; fill_en = 1'b0;
    fill_rows('h0200, 'h0200);
    send_line(8, 4);
    idle(3);

    // window rescue: column 6 targets column 4
    fill_rows('h0200, 'h0200);
    dr[3] = 'h0210; dr[4] = 'h0500; dr[5] = 'h0900;
    send_line(8, -1);
    idle(3);
    win_sel = 2'b01;
    send_line(8, -1);
    idle(3);

    // fill, then column 0 of the next line is invalid
    win_sel = 2'b00; fill_en = 1'b1;
    fill_rows('h0200, 'h0200);
    dr[2] = 'h0900;
    send_line(8, -1);
    dl[0] = 0;
    send_line(8, -1);
    idle(3);

    // range limit and rounding
    img_width = 11'd16; range_v = 9'd8; fill_en = 1'b0;
    fill_rows('h0180, 'h0200);
    dl[12] = 'h0A00;
    send_line(16, -1);
    dl[12] = 'h0180;
    send_line(16, -1);
    idle(3);

    // reset mid-line at column 5, then latency and line_end after release
    img_width = 11'd8; range_v = 9'd100;
    fill_rows('h0200, 'h0200);
    for (int c = 0; c < 5; c++) drive(1'b1, 1'b1, dl[c], dr[c]);
    valid_in = 1'b0;
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_valid_out", 32'(valid_out), 0);
    check("midreset_disp_out", 32'(disp_out), 0);
    check("midreset_flag_out", 32'(flag_out), 0);
    check("midreset_line_end", 32'(line_end), 0);
    sb.delete();
    m_col = 0;
    m_lg = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 1'b1, dl[0], dr[0]);
    @(negedge clk);
    check("latency_cycle1", 32'(valid_out), 0);
    drive(1'b1, 1'b1, dl[1], dr[1]);
    @(negedge clk);
    check("latency_cycle2", 32'(valid_out), 1);
    for (int c = 2; c < 8; c++) drive(1'b1, 1'b1, dl[c], dr[c]);
    idle(3);

    // randomized frames with stalls and bubbles
    for (int f = 0; f < 14; f++) begin
      idle(3);
      img_width = AW'($urandom_range(2, 40));
      for (int ln = 0; ln < 3; ln++) begin
        idle(3);
        range_v  = 9'($urandom_range(2, 15));
        win_sel  = 2'($urandom_range(0, 3));
        check_th = DW'($urandom_range(16, 288));
        fill_en  = 1'($urandom_range(0, 1));
        rand_line();
      end
    end

    // bounded drain
    for (int i = 0; i < 20 && sb.size() > 0; i++) drive(1'b1, 1'b0, 0, 0);
    check("drain_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
